// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with locked multi-cycle grants for N requesters.
// A grant stays with its owner until the owner asserts done, drops its
// request, or has held the grant for MAX_HOLD cycles. Every release is
// followed by one idle cycle, which serves as the handover cycle for the
// shared resource.
//
// Ports:
//   clk       input   1    rising-edge clock
//   reset     input   1    asynchronous active-high reset
//   req       input   N    per-requester level request
//   done      input   N    per-requester release strobe (owner bit only)
//   grant     output  N    registered one-hot grant, zero when idle
//   grant_id  output  IDW  index of current/last owner
//   busy      output  1    high whenever a grant is active
//   timeout   output  1    one-cycle pulse after a forced release
module rr_lock_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] id_d;
  logic           busy_d;
  logic           timeout_d;

  logic [IDW-1:0] sel;
  logic           found;
  int unsigned    idx;

  // Round-robin search: first set request at or above ptr, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant    <= grant_d;
      grant_id <= id_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant;
    id_d      = grant_id;
    busy_d    = busy;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done is deliberately not looked at here, so it is never stored.
        if (found) begin
          grant_d = N'(1) << sel;
          id_d    = sel;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (done[grant_id] || !req[grant_id] || (cnt_q == CW'(MAX_HOLD))) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          ptr_d     = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
          // Forced only when neither done nor withdrawal caused the release.
          timeout_d = !done[grant_id] && req[grant_id];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed self-checking bench for rr_lock_arbiter (N=4, MAX_HOLD=4).
module tb_rr_lock_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IDW      = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  int checks;
  int errors;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".id"}, 32'(grant_id), 32'(id));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    done  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = '0;
    done   = '0;
    #2;
    chk_out("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    do_reset();
    chk_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 1: single requester, done in 3rd grant cycle
    req = 4'b0100;
    step(); chk_out("t1.c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk_out("t1.c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step(); chk_out("t1.c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 4'b0100;
    step(); chk_out("t1.rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = '0;
    req  = 4'b0000;

    // 4: ptr is now 3; owner 3 withdraws in its 2nd cycle, next grant wraps to 0
    req = 4'b1011;
    step(); chk_out("t4.c1", 4'b1000, 2'd3, 1'b1, 1'b0);
    step(); chk_out("t4.c2", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0011;
    step(); chk_out("t4.rel", 4'b0000, 2'd3, 1'b0, 1'b0);
    step(); chk_out("t4.wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 2: full contention, forced releases
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_out($sformatf("t2.g%0d.c%0d", g, c), 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
      end
      if (g < 4) begin
        step();
        chk_out($sformatf("t2.gap%0d", g), 4'b0000, 2'(g % 4), 1'b0, 1'b1);
      end
    end

    // 3: foreign done ignored, owner done honoured
    do_reset();
    done = 4'b1111;
    step(); chk_out("t3.idle_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = '0;
    req  = 4'b0010;
    step(); chk_out("t3.c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 4'b1101;
    step(); chk_out("t3.foreign", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 4'b0010;
    step(); chk_out("t3.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    done = '0;

    // 5: done coincides with hold limit -> normal release
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("t5.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    done = 4'b0001;
    step(); chk_out("t5.rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = '0;
    step(); chk_out("t5.regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // 6: async reset during grant 0100
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 11; c++) step();
    chk_out("t6.pre", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step(); chk_out("t6.first", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parameterised round-robin arbiter for N requesters sharing one resource.
- A grant is locked to its owner until the owner signals done, withdraws its request, or exceeds a maximum hold time.
- Sits between requesting masters and a shared datapath resource such as a bus port or memory bank.
- Extends the two-requester fair scheme to N requesters with multi-cycle ownership and starvation protection.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive cycles a grant may stay high (>=2).
- IDW, $clog2(N), width of grant_id (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request, level.
- done  input  N  per-requester release strobe; only the current owner's bit is honoured.
- grant  output  N  one-hot registered grant, all-zero when idle.
- grant_id  output  IDW  index of current owner; holds last owner when idle.
- busy  output  1  high whenever any grant bit is high.
- timeout  output  1  one-cycle pulse marking a forced release.

Behaviour:
- Reset (async, immediate):
  - grant=0, grant_id=0, busy=0, timeout=0.
  - State=IDLE, rotation pointer ptr=0, hold counter=0.
  - A reset during an active grant drops grant in the same cycle.
- State IDLE:
  - If req!=0 at a clock edge, select the first set req bit searching upward from ptr with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - After that edge: grant=onehot(sel), grant_id=sel, busy=1, counter=1, state=GRANT.
  - Latency is 1 cycle from sampled req to grant.
  - If req==0, remain IDLE.
- State GRANT (owner o):
  - Each edge evaluates release conditions in priority order:
    - a) done[o]=1: normal release.
    - b) req[o]=0: withdrawal release.
    - c) counter==MAX_HOLD: forced release.
  - Otherwise counter increments.
  - On any release, after the edge: grant=0, busy=0, state=IDLE, ptr=(o+1) mod N. grant_id keeps o.
  - On forced release only: timeout=1 for exactly the first idle cycle.
- Grant rules:
  - Grant is high for at most MAX_HOLD consecutive cycles.
  - Between two grants there is always exactly one idle cycle when requests are continuous. This gap is the handover cycle for the shared resource.
- Boundary conditions:
  - done bits of non-owners are ignored in every state.
  - done while IDLE is ignored; it is not stored.
  - done[o] and counter==MAX_HOLD in the same cycle: treat as normal release, no timeout pulse.
  - Owner withdraws req and asserts done in the same cycle: normal release, single release.
  - A requester re-asserting immediately after its own release has lowest priority in the next arbitration (ptr has moved past it).
  - Only a single requester active: it is re-granted after each one-cycle gap, so no requester is ever starved.
  - ptr wraps N-1 -> 0.
- Invariants:
  - grant is always one-hot or zero.
  - busy equals |grant.
  - timeout never coincides with grant!=0.

Test Plan:
(N=4, MAX_HOLD=4 throughout.)
1. Single request: reset, then req=0100 from cycle 0; done[2]=1 in the 3rd grant cycle -> grant=0100, grant_id=2 from cycle 1 for 3 cycles, then grant=0, ptr=3, timeout stays 0.
2. Full contention: req=1111 held, done=0 -> grants 0001, 0010, 0100, 1000, 0001, each 4 cycles long, separated by one idle cycle, with timeout=1 in every idle cycle.
3. Foreign done: owner 1, done=1101 pulsed (owner bit clear) -> no release. Then done=0010 -> release next edge, no timeout.
4. Withdrawal: owner 3 drops req[3] in its 2nd grant cycle with req=1011 -> grant=0 next cycle, then grant=0001 (wrap to 0), timeout=0.
5. Coincidence: done[o] asserted exactly in the 4th grant cycle -> release with timeout=0.
6. Async reset while grant=0100 with req=1111 -> grant=0 immediately. After reset release, the first grant goes to 0001 (ptr=0).
